// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   ALU operation codes   : 4-bit ALUcontrolE encodings
//   Branch condition codes: 3-bit funct3 encodings on BranchTypeE
//   Forward-select codes  : 2-bit ForwardAE/ForwardBE encodings
//   mul_state_e           : state of the shift-add multiplier FSM
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // 2'b11 is not listed: it falls back to the register-file operand.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier, one multiplier bit per cycle.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   mul_op_i      : the instruction in E is a multiply
//   flush_i       : kill the instruction in E; aborts a multiply in flight
//   a_i, b_i      : multiplicand / multiplier, sampled only in the issue cycle
//   busy_o        : stall request while the multiply occupies E
//   product_o     : low XLEN bits of the product, valid while state_o==MUL_DONE
//   state_o       : current FSM state (also used by the top to pick the result)
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mul_op_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic [XLEN-1:0] product_o,
    output mul_state_e      state_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start;

    assign start = (state_q == MUL_IDLE) & mul_op_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= MUL_IDLE;
        else         state_q <= state_d;
    end

    // A flush overrides every transition, including the DONE handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_RUN;
            MUL_RUN:  if (cnt_q == LAST_CNT) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
        if (flush_i) state_d = MUL_IDLE;
    end

    always_comb begin
        busy_o    = start | (state_q == MUL_RUN);
        product_o = acc_q;
        state_o   = state_q;
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (state_q == MUL_RUN) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and a
// multi-cycle multiplier, feeding the E->M pipeline register.
//   Inputs : decoded controls, ALUcontrolE, BranchTypeE, ForwardAE/BE, FlushE,
//            RD1E/RD2E/PCE/ImmExtE/PCPlus4E/ResultW operands, RdE
//   Outputs: registered RegWriteM/ResultSrcM/MemWriteM/ALUResultM/WriteDataM/
//            PCPlus4M/RdM; combinational PCTargetE, PCSrcE, BusyE
// Stall handshake: while BusyE=1 the upstream stages hold every E input
// stable and the M register receives a bubble; the cycle BusyE drops (DONE
// for a multiply) the instruction retires into M and upstream may advance.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUcontrolE,
    input  logic [2:0]      BranchTypeE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [REGW-1:0] RdE,
    output logic            RegWriteM,
    output logic            ResultSrcM,
    output logic            MemWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [REGW-1:0] RdM,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            BusyE
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res, ex_result, mul_product;
    logic [SHW-1:0]  shamt;
    logic            cond, is_mul, bubble;
    mul_state_e      mul_state;

    logic            regwrite_q, resultsrc_q, memwrite_q;
    logic [XLEN-1:0] aluresult_q, writedata_q, pcplus4_q;
    logic [REGW-1:0] rd_q;

    always_comb begin
        case (ForwardAE)
            FWD_W:   fwd_a = ResultW;
            FWD_M:   fwd_a = ALUResultM;
            default: fwd_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_W:   fwd_b = ResultW;
            FWD_M:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : fwd_b;
    assign shamt = src_b[SHW-1:0];

    // MUL yields 0 here; the real product only enters M in the DONE cycle.
    always_comb begin
        alu_res = '0;
        case (ALUcontrolE)
            ALU_ADD:  alu_res = fwd_a + src_b;
            ALU_SUB:  alu_res = fwd_a - src_b;
            ALU_AND:  alu_res = fwd_a & src_b;
            ALU_OR:   alu_res = fwd_a | src_b;
            ALU_XOR:  alu_res = fwd_a ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            ALU_SLL:  alu_res = fwd_a << shamt;
            ALU_SRL:  alu_res = fwd_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    // Branches compare the forwarded operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (BranchTypeE)
            BR_EQ:   cond = (fwd_a == fwd_b);
            BR_NE:   cond = (fwd_a != fwd_b);
            BR_LT:   cond = ($signed(fwd_a) < $signed(fwd_b));
            BR_GE:   cond = ($signed(fwd_a) >= $signed(fwd_b));
            BR_LTU:  cond = (fwd_a < fwd_b);
            BR_GEU:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = ~FlushE & (JumpE | (BranchE & cond));
    assign is_mul    = (ALUcontrolE == ALU_MUL);

    if (MUL_EN) begin : g_mul
        seq_multiplier #(.XLEN(XLEN)) u_mul (
            .clk_i    (clk),
            .rst_ni   (rst),
            .mul_op_i (is_mul),
            .flush_i  (FlushE),
            .a_i      (fwd_a),
            .b_i      (src_b),
            .busy_o   (BusyE),
            .product_o(mul_product),
            .state_o  (mul_state)
        );
    end else begin : g_no_mul
        assign BusyE       = 1'b0;
        assign mul_product = '0;
        assign mul_state   = MUL_IDLE;
    end

    assign ex_result = (mul_state == MUL_DONE) ? mul_product : alu_res;
    assign bubble    = FlushE | BusyE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            aluresult_q <= '0;
            writedata_q <= '0;
            pcplus4_q   <= '0;
            rd_q        <= '0;
        end else begin
            regwrite_q  <= RegWriteE;
            resultsrc_q <= ResultSrcE;
            memwrite_q  <= MemWriteE;
            aluresult_q <= ex_result;
            writedata_q <= fwd_b;
            pcplus4_q   <= PCPlus4E;
            rd_q        <= RdE;
        end
    end

    assign RegWriteM  = regwrite_q;
    assign ResultSrcM = resultsrc_q;
    assign MemWriteM  = memwrite_q;
    assign ALUResultM = aluresult_q;
    assign WriteDataM = writedata_q;
    assign PCPlus4M   = pcplus4_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
    logic [3:0]      ALUcontrolE;
    logic [2:0]      BranchTypeE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            FlushE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [REGW-1:0] RdE;
    logic            RegWriteM, ResultSrcM, MemWriteM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
    logic [REGW-1:0] RdM;
    logic            PCSrcE, BusyE;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [XLEN-1:0] m_alu;   // model of what ALUResultM should hold

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    execute_stage_mc #(.XLEN(XLEN), .REGW(REGW), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ALUcontrolE(ALUcontrolE), .BranchTypeE(BranchTypeE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FlushE(FlushE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RdE(RdE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] r;
        s = b[4:0];
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << s;
            4'd8: r = a >> s;
            4'd9: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            4'd10: r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_cond(input logic [2:0] bt, input logic [31:0] a,
                                      input logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (bt)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return slt;
            3'b101: return !slt;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
        ALUcontrolE = 4'd0; BranchTypeE = 3'd0; ForwardAE = 2'd0; ForwardBE = 2'd0;
        FlushE = 0; RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0;
        ResultW = '0; RdE = '0;
    endtask

    // Push one bubble through M so m_alu is known to be zero.
    task automatic flush_pipe();
        @(negedge clk);
        drive_nop();
        FlushE = 1;
        @(negedge clk);
        FlushE = 0;
        m_alu = '0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] imm,
                             input logic [4:0] rd);
        drive_nop();
        ALUcontrolE = op; RD1E = a; ALUSrcE = 1; ImmExtE = imm; RegWriteE = 1; RdE = rd;
    endtask

    task automatic drive_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        drive_nop();
        ALUcontrolE = 4'd10; RD1E = a; RD2E = b; RegWriteE = 1; RdE = rd;
        PCPlus4E = 32'h100 + 32'(rd);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        drive_nop();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RdM} !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs got %h required 0",
                     {RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RdM});
        end
        tests_run++;
        if (BusyE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b required 0", BusyE);
        end
        @(negedge clk);
        rst = 1;
        m_alu = '0;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        drive_alu(4'd0, 32'd7, 32'd0, 5'd1);
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd7) begin
            tests_failed++;
            $display("FAIL fwd_setup got %h required 7", ALUResultM);
        end
        drive_alu(4'd0, 32'd5, 32'd3, 5'd2);
        ForwardAE = 2'b10;
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd10) begin
            tests_failed++;
            $display("FAIL fwd_mem got %h required 10", ALUResultM);
        end
        drive_alu(4'd0, 32'd5, 32'd3, 5'd3);
        ForwardAE = 2'b01; ForwardBE = 2'b01; ResultW = 32'd1; RD2E = 32'd99;
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd4 || WriteDataM !== 32'd1) begin
            tests_failed++;
            $display("FAIL fwd_wb got %h/%h required 4/1", ALUResultM, WriteDataM);
        end
        drive_alu(4'd0, 32'd20, 32'd3, 5'd4);
        ForwardAE = 2'b11; ResultW = 32'd1000;
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd23) begin
            tests_failed++;
            $display("FAIL fwd_11 got %h required 23", ALUResultM);
        end
        flush_pipe();
    endtask

    task automatic test_signed_ops();
        @(negedge clk);
        drive_alu(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd1);
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd1) begin
            tests_failed++;
            $display("FAIL slt got %h required 1", ALUResultM);
        end
        drive_alu(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd1);
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'd0) begin
            tests_failed++;
            $display("FAIL sltu got %h required 0", ALUResultM);
        end
        drive_alu(4'd9, 32'h8000_0000, 32'd4, 5'd1);
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'hF800_0000) begin
            tests_failed++;
            $display("FAIL sra got %h required f8000000", ALUResultM);
        end
        flush_pipe();
    endtask

    task automatic test_branch();
        logic [2:0]  bt_t[4]  = '{3'b101, 3'b110, 3'b001, 3'b000};
        logic [31:0] a_t[4]   = '{32'hFFFF_FFFF, 32'd1, 32'd42, 32'd1};
        logic [31:0] b_t[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd42, 32'd2};
        logic        j_t[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        f_t[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_nop();
            BranchE = ~j_t[i]; JumpE = j_t[i]; FlushE = f_t[i]; BranchTypeE = bt_t[i];
            RD1E = a_t[i]; RD2E = b_t[i]; ALUSrcE = 1; ImmExtE = 32'h40; PCE = 32'h1000;
            #1;
            tests_run++;
            if (PCSrcE !== exp_t[i] || PCTargetE !== 32'h1040) begin
                tests_failed++;
                $display("FAIL branch_%0d got %b/%h required %b/00001040", i, PCSrcE, PCTargetE,
                         exp_t[i]);
            end
        end
        flush_pipe();
    endtask

    task automatic test_random_alu();
        logic [3:0]  op;
        logic [1:0]  fa, fb;
        logic [2:0]  bt;
        logic        fl, rw, mw, rs, br, jp, as;
        logic [31:0] a, b, sb, exp;
        logic [4:0]  rd;
        logic        exp_pc;
        @(negedge clk);
        for (int it = 0; it < 200; it++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd10) op = 4'd0;
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            bt = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 7) == 0);
            rw = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
            jp = ($urandom_range(0, 3) == 0); as = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            ALUcontrolE = op; ForwardAE = fa; ForwardBE = fb; BranchTypeE = bt; FlushE = fl;
            RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; BranchE = br; JumpE = jp;
            ALUSrcE = as; RdE = rd;
            RD1E = $urandom; RD2E = (it % 4 == 0) ? RD1E : $urandom;
            ResultW = $urandom; PCE = $urandom; PCPlus4E = $urandom;
            ImmExtE = (it % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            a  = (fa == 2'b01) ? ResultW : (fa == 2'b10) ? m_alu : RD1E;
            b  = (fb == 2'b01) ? ResultW : (fb == 2'b10) ? m_alu : RD2E;
            sb = as ? ImmExtE : b;
            exp = ref_alu(op, a, sb);
            exp_pc = !fl && (jp || (br && ref_cond(bt, a, b)));
            #1;
            tests_run++;
            if (PCSrcE !== exp_pc || PCTargetE !== PCE + ImmExtE || BusyE !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_comb[%0d] got pcsrc=%b tgt=%h busy=%b required %b %h 0", it,
                         PCSrcE, PCTargetE, BusyE, exp_pc, PCE + ImmExtE);
            end
            @(negedge clk);
            if (fl) begin
                exp = '0; b = '0; rw = 0; mw = 0; rs = 0; rd = '0;
            end
            tests_run++;
            if (ALUResultM !== exp || WriteDataM !== b || RdM !== rd || RegWriteM !== rw ||
                MemWriteM !== mw || ResultSrcM !== rs || PCPlus4M !== (fl ? 32'd0 : PCPlus4E)) begin
                tests_failed++;
                $display("FAIL rand_m[%0d] op=%0d got res=%h wd=%h rd=%0d rw=%b required %h %h %0d %b",
                         it, op, ALUResultM, WriteDataM, RdM, RegWriteM, exp, b, rd, rw);
            end
            m_alu = exp;
        end
        flush_pipe();
    endtask

    // Consecutive multiplies: each new MUL issues in the cycle after DONE.
    task automatic test_mul_back_to_back();
        logic [31:0] a_t[4];
        logic [31:0] b_t[4];
        int busy_cnt, rw_bad;
        a_t[0] = 32'h0001_0003; b_t[0] = 32'h0000_0005;
        a_t[1] = 32'hFFFF_FFFF; b_t[1] = 32'hFFFF_FFFF;
        for (int i = 2; i < 4; i++) begin
            a_t[i] = $urandom; b_t[i] = $urandom;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_mul(a_t[i], b_t[i], 5'(i + 1));
            if (i == 2) begin
                ForwardAE = 2'b01; ResultW = a_t[i]; RD1E = ~a_t[i];
            end
            busy_cnt = 0; rw_bad = 0;
            for (int g = 0; g < 100; g++) begin
                #1;
                if (!BusyE) break;
                busy_cnt++;
                if (g > 0 && RegWriteM !== 1'b0) rw_bad++;
                @(negedge clk);
                if (i == 2) ResultW = $urandom;
            end
            tests_run++;
            if (busy_cnt != XLEN + 1 || rw_bad != 0) begin
                tests_failed++;
                $display("FAIL mul_busy[%0d] got busy=%0d rw_bad=%0d required %0d 0", i,
                         busy_cnt, rw_bad, XLEN + 1);
            end
            @(negedge clk);
            tests_run++;
            if (ALUResultM !== ref_alu(4'd10, a_t[i], b_t[i]) || RegWriteM !== 1'b1 ||
                RdM !== 5'(i + 1) || WriteDataM !== b_t[i]) begin
                tests_failed++;
                $display("FAIL mul_result[%0d] got %h rw=%b rd=%0d required %h 1 %0d", i,
                         ALUResultM, RegWriteM, RdM, ref_alu(4'd10, a_t[i], b_t[i]), i + 1);
            end
            m_alu = ref_alu(4'd10, a_t[i], b_t[i]);
        end
        flush_pipe();
    endtask

    task automatic test_flush_abort();
        @(negedge clk);
        drive_mul(32'd1234, 32'd77, 5'd3);
        repeat (11) @(negedge clk);
        FlushE = 1; ALUcontrolE = 4'd0;
        @(negedge clk);
        drive_alu(4'd0, 32'h1234, 32'd1, 5'd7);
        #1;
        tests_run++;
        if (BusyE !== 1'b0 || RegWriteM !== 1'b0 || RdM !== '0 || ALUResultM !== '0) begin
            tests_failed++;
            $display("FAIL flush_abort got busy=%b rw=%b rd=%0d res=%h required 0 0 0 0", BusyE,
                     RegWriteM, RdM, ALUResultM);
        end
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'h1235 || RdM !== 5'd7) begin
            tests_failed++;
            $display("FAIL flush_next got %h rd=%0d required 1235 7", ALUResultM, RdM);
        end
        flush_pipe();
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        drive_alu(4'd3, 32'hA5A5_0000, 32'h5A5A, 5'd12);
        PCPlus4E = 32'h44; MemWriteE = 1; ResultSrcE = 1;
        @(negedge clk);
        rst = 0;
        #1;
        tests_run++;
        if ({RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RdM} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset got res=%h rd=%0d required 0", ALUResultM, RdM);
        end
        @(negedge clk);
        rst = 1;
        drive_mul(32'd99, 32'd3, 5'd4);
        repeat (6) @(negedge clk);
        rst = 0; ALUcontrolE = 4'd0;
        #1;
        tests_run++;
        if (BusyE !== 1'b0 || ALUResultM !== '0 || RegWriteM !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_run got busy=%b res=%h required 0 0", BusyE, ALUResultM);
        end
        @(negedge clk);
        rst = 1;
        drive_alu(4'd0, 32'h55, 32'd0, 5'd9);
        #1;
        tests_run++;
        if (BusyE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle got busy=%b required 0", BusyE);
        end
        @(negedge clk);
        tests_run++;
        if (ALUResultM !== 32'h55 || RdM !== 5'd9) begin
            tests_failed++;
            $display("FAIL reset_after got %h rd=%0d required 55 9", ALUResultM, RdM);
        end
        flush_pipe();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_forwarding();
        test_signed_ops();
        test_branch();
        test_random_alu();
        test_mul_back_to_back();
        test_flush_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
